sar_compare_ctrl: RTL and testbench
===================================

// Module: sar_compare_ctrl
// PURPOSE
//   Successive-approximation controller for the 8-bit magnitude comparator.
//   - Drives the comparator's B operand with trial codes and reads back its ge result.
//   - Binary-searches for the largest code C with A >= C, where A is the unknown operand
//     on the comparator's A side.
//   - Sits on the comparator's output end: trial -> comparator b_*, comparator q -> cmp_ge.
// PARAMETERS
//   WIDTH    8  operand width; one search step per bit
//   CMP_LAT  2  register stages in the comparator path; 0 = purely combinational
// PORTS
//   clk      in   1      single clock; all logic rising-edge
//   rst_n    in   1      asynchronous, active-low reset
//   start    in   1      request a search; accepted only in IDLE
//   abort    in   1      synchronous cancel of a running search
//   cmp_ge   in   1      comparator result: 1 when A >= trial, CMP_LAT cycles after trial
//   trial    out  WIDTH  code presented to comparator B input
//   busy     out  1      high from the cycle after start is accepted until done
//   done     out  1      one-cycle pulse; result valid and updated
//   result   out  WIDTH  last completed search value; holds until next done
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - State IDLE; trial, result, busy, done, bit index and wait counter are all 0.
//   States:
//   - IDLE: start=1 -> TEST; on the same edge: trial<=1<<(WIDTH-1), acc<=0,
//     idx<=WIDTH-1, cnt<=CMP_LAT.
//   - TEST: busy=1. If cnt!=0, cnt<=cnt-1. Else sample cmp_ge:
//     - acc[idx] <= cmp_ge. If idx==0 -> DONE.
//     - Otherwise idx<=idx-1, trial<=(acc with bit idx=cmp_ge)|(1<<(idx-1)), cnt<=CMP_LAT.
//   - DONE: exactly one cycle. done=1, busy=0, result=acc, trial=acc. Then -> IDLE.
//   Timing and handshake:
//   - Each bit takes CMP_LAT+1 cycles.
//   - With start sampled at edge 0, done is high in the cycle after edge WIDTH*(CMP_LAT+1).
//   - IDLE holds trial at its last value (final result or 0); this keeps the comparator quiet.
//   - start is ignored in TEST and DONE; no queuing. It must be re-asserted in IDLE.
//   Abort and reset mid-search:
//   - abort=1 in TEST -> IDLE next edge; trial<=0; result unchanged; no done pulse.
//   - abort has priority over a same-cycle final sample.
//   - abort in IDLE or DONE has no effect; DONE still pulses.
//   - start and abort together in IDLE: abort wins, start is dropped.
//   - Reset mid-search clears everything; no done pulse.
//   Data path:
//   - Arithmetic is bit-set only; no adders. idx is $clog2(WIDTH) bits.
//   - cnt is max($clog2(CMP_LAT+1),1) bits.
//   - cmp_ge is sampled only at the cnt==0 edge; glitches or X between samples are ignored.
// TESTING
//   Bench model: cmp_ge = (A >= trial) through CMP_LAT flops.
//   1. CMP_LAT=2, A=8'h5A, pulse start -> done at cycle 24 after start edge; result=8'h5A;
//      trial sequence 80,40,60,50,58,5C,5A,5B.
//   2. Boundaries: A=8'h00 -> result 00; A=8'hFF -> result FF; trial after done equals result.
//   3. CMP_LAT=0, A=8'h81 -> done 8 cycles after start; result 81. Sweep all 256 A values,
//      all must match.
//   4. A=8'h33, abort at cycle 10 -> busy falls next cycle; no done; result keeps previous;
//      trial=0. A new start then returns 33.
//   5. start held high through a whole search -> exactly one done. Restart occurs only
//      from IDLE, one cycle after DONE.
//   6. rst_n low mid-search (cycle 7), asynchronous to clk -> outputs 0 immediately; no done.
//      After release, a search with A=8'hC4 returns C4.

Source files
------------

// File: rtl/sar_compare_ctrl.sv
// Purpose: successive-approximation search for the largest trial code C with A >= C, driven through an external comparator.
// Latency: WIDTH*(CMP_LAT+1) cycles from the start edge to the done pulse; done lasts exactly one cycle.
// Backpressure: none; start is only accepted in IDLE, abort cancels a running search without a done pulse.
module sar_compare_ctrl #(
   parameter int WIDTH   = 8,
   parameter int CMP_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp_ge,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = ($clog2(CMP_LAT + 1) > 1) ? $clog2(CMP_LAT + 1) : 1;

   localparam logic [IW-1:0]    IDX_TOP  = IW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_INIT = CW'(CMP_LAT);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] MSB      = ONE << (WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TEST = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt, acc_set;
   logic [WIDTH-1:0] trial_nxt, result_nxt;
   logic [IW-1:0]    idx, idx_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;

   // Status flags are pure decodes of the state so they track it with no extra delay.
   assign busy = (state == TEST);
   assign done = (state == DONE);

   // State and datapath registers; everything clears on reset, including mid-search.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         trial  <= '0;
         result <= '0;
         acc    <= '0;
         idx    <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_nxt;
         trial  <= trial_nxt;
         result <= result_nxt;
         acc    <= acc_nxt;
         idx    <= idx_nxt;
         cnt    <= cnt_nxt;
      end
   end

   // Next-state and datapath: cnt absorbs the comparator pipeline, then one bit is resolved per sample.
   always_comb begin
      state_nxt  = state;
      trial_nxt  = trial;
      result_nxt = result;
      acc_nxt    = acc;
      idx_nxt    = idx;
      cnt_nxt    = cnt;
      acc_set      = acc;
      acc_set[idx] = cmp_ge;
      case (state)
         IDLE: begin
            // abort beats a simultaneous start, so the request is dropped
            if (start && !abort) begin
               state_nxt = TEST;
               trial_nxt = MSB;
               acc_nxt   = '0;
               idx_nxt   = IDX_TOP;
               cnt_nxt   = CNT_INIT;
            end
         end
         TEST: begin
            if (abort) begin
               // abort also wins over a final sample on the same edge
               state_nxt = IDLE;
               trial_nxt = '0;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               acc_nxt = acc_set;
               if (idx == '0) begin
                  state_nxt  = DONE;
                  result_nxt = acc_set;
                  trial_nxt  = acc_set;
               end else begin
                  idx_nxt   = idx - 1'b1;
                  trial_nxt = acc_set | (ONE << (idx - 1'b1));
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         DONE: begin
            // start is ignored here; a restart needs a fresh sample in IDLE
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sar_compare_ctrl.sv
// Bench for sar_compare_ctrl: one instance with a 2-stage comparator model, one with a combinational one.
// Expected results and done cycles are queued at start time and popped by monitors on done.
module tb_sar_compare_ctrl;

   logic clk;
   logic rst_n;

   logic       start2, abort2, ge2, busy2, done2;
   logic [7:0] trial2, result2, a2;
   logic       start0, abort0, ge0, busy0, done0;
   logic [7:0] trial0, result0, a0;
   logic       p1, p2;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   typedef struct {
      logic [7:0] res;
      int         cyc;
   } exp_t;

   exp_t q2[$];
   exp_t q0[$];

   sar_compare_ctrl #(.WIDTH(8), .CMP_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .cmp_ge(ge2),
      .trial(trial2), .busy(busy2), .done(done2), .result(result2)
   );

   sar_compare_ctrl #(.WIDTH(8), .CMP_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .cmp_ge(ge0),
      .trial(trial0), .busy(busy0), .done(done0), .result(result0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // comparator models: A >= trial, through two flops and through none
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= 1'b0;
         p2 <= 1'b0;
      end else begin
         p1 <= (a2 >= trial2);
         p2 <= p1;
      end
   end
   assign ge2 = p2;
   assign ge0 = (a0 >= trial0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // monitors: every done must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && done2) begin
         if (q2.size() == 0) begin
            chk("d2_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("d2_result", {24'd0, result2}, {24'd0, e.res});
            chk("d2_trial_after_done", {24'd0, trial2}, {24'd0, e.res});
            chk("d2_done_cycle", cyc, e.cyc);
            chk("d2_busy_in_done", {31'd0, busy2}, 32'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done0) begin
         if (q0.size() == 0) begin
            chk("d0_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q0.pop_front();
            chk("d0_result", {24'd0, result0}, {24'd0, e.res});
            chk("d0_done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic do_start2(input logic [7:0] a, input logic [7:0] res, input bit push, output int c0);
      @(negedge clk);
      a2 = a;
      start2 = 1'b1;
      c0 = cyc;
      if (push) q2.push_back('{res, cyc + 25});
   endtask

   task automatic wait_q2();
      for (int i = 0; i < 200; i++) begin
         if (q2.size() == 0) break;
         @(negedge clk);
      end
      if (q2.size() != 0) begin
         chk("d2_done_timeout", q2.size(), 32'd0);
         q2.delete();
      end
   endtask

   task automatic wait_q0();
      for (int i = 0; i < 100; i++) begin
         if (q0.size() == 0) break;
         @(negedge clk);
      end
      if (q0.size() != 0) begin
         chk("d0_done_timeout", q0.size(), 32'd0);
         q0.delete();
      end
   endtask

   task automatic run2(input logic [7:0] a, input logic [7:0] res);
      int c0;
      do_start2(a, res, 1'b1, c0);
      @(negedge clk);
      start2 = 1'b0;
      wait_q2();
   endtask

   task automatic run0(input logic [7:0] a, input logic [7:0] res);
      @(negedge clk);
      a0 = a;
      start0 = 1'b1;
      q0.push_back('{res, cyc + 9});
      @(negedge clk);
      start0 = 1'b0;
      wait_q0();
   endtask

   logic [7:0] seq [8];

   initial begin
      int c0;
      seq[0] = 8'h80; seq[1] = 8'h40; seq[2] = 8'h60; seq[3] = 8'h50;
      seq[4] = 8'h58; seq[5] = 8'h5C; seq[6] = 8'h5A; seq[7] = 8'h5B;
      rst_n = 1'b0;
      start2 = 1'b0; abort2 = 1'b0; a2 = 8'h00;
      start0 = 1'b0; abort0 = 1'b0; a0 = 8'h00;

      // reset state
      #3;
      chk("rst_trial2", {24'd0, trial2}, 32'd0);
      chk("rst_result2", {24'd0, result2}, 32'd0);
      chk("rst_busy2", {31'd0, busy2}, 32'd0);
      chk("rst_done2", {31'd0, done2}, 32'd0);
      chk("rst_trial0", {24'd0, trial0}, 32'd0);
      chk("rst_result0", {24'd0, result0}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // A=5A with CMP_LAT=2: trial steps every 3 cycles, done 24 edges after start
      do_start2(8'h5A, 8'h5A, 1'b1, c0);
      for (int k = 0; k < 8; k++) begin
         wait_until(c0 + 1 + 3 * k);
         start2 = 1'b0;
         chk("t1_trial_seq", {24'd0, trial2}, {24'd0, seq[k]});
         chk("t1_busy", {31'd0, busy2}, 32'd1);
      end
      wait_q2();

      // boundaries
      run2(8'h00, 8'h00);
      run2(8'hFF, 8'hFF);

      // combinational comparator, then a full sweep
      run0(8'h81, 8'h81);
      for (int a = 0; a < 256; a++) run0(8'(a), 8'(a));

      // abort mid-search: no done, result kept, trial cleared
      do_start2(8'h33, 8'h00, 1'b0, c0);
      wait_until(c0 + 1);
      start2 = 1'b0;
      wait_until(c0 + 10);
      chk("t4_busy_before_abort", {31'd0, busy2}, 32'd1);
      abort2 = 1'b1;
      wait_until(c0 + 11);
      abort2 = 1'b0;
      chk("t4_busy_after_abort", {31'd0, busy2}, 32'd0);
      chk("t4_trial_after_abort", {24'd0, trial2}, 32'd0);
      chk("t4_result_kept", {24'd0, result2}, 32'hFF);
      repeat (30) @(negedge clk);
      chk("t4_result_still_kept", {24'd0, result2}, 32'hFF);
      run2(8'h33, 8'h33);

      // start together with abort in IDLE is dropped
      @(negedge clk);
      start2 = 1'b1;
      abort2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      abort2 = 1'b0;
      chk("t4_start_abort_idle", {31'd0, busy2}, 32'd0);

      // start held high: one done, then restart only from IDLE one cycle later
      do_start2(8'hA7, 8'hA7, 1'b1, c0);
      wait_until(c0 + 25);
      chk("t5_done_seen", {31'd0, done2}, 32'd1);
      wait_until(c0 + 26);
      chk("t5_idle_busy", {31'd0, busy2}, 32'd0);
      chk("t5_idle_done", {31'd0, done2}, 32'd0);
      q2.push_back('{8'hA7, cyc + 25});
      wait_until(c0 + 27);
      chk("t5_restart_busy", {31'd0, busy2}, 32'd1);
      start2 = 1'b0;
      wait_q2();

      // asynchronous reset mid-search
      do_start2(8'h55, 8'h00, 1'b0, c0);
      wait_until(c0 + 1);
      start2 = 1'b0;
      wait_until(c0 + 7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_trial", {24'd0, trial2}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy2}, 32'd0);
      chk("t6_rst_result", {24'd0, result2}, 32'd0);
      chk("t6_rst_done", {31'd0, done2}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      run2(8'hC4, 8'hC4);

      repeat (3) @(negedge clk);
      chk("end_q2_empty", q2.size(), 32'd0);
      chk("end_q0_empty", q0.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
